udp_rx_port_demux: RTL and testbench

// Multi-port UDP receive stage. Sits between the IP RX layer and user logic.

---
 rtl/udp_rx_port_demux.sv | 217 +++++++++++++++++++++
 tb/tb_udp_rx_port_demux.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_port_demux.sv
// UDP receive demultiplexer: matches the destination port of each packet against a
// programmable port table and forwards the payload of matching packets with a channel tag.
module udp_rx_port_demux #(
    parameter int unsigned                P_CHANNELS  = 4,
    // Channel i owns bits [16i+15:16i], so the default table is ch0=0x0808 .. ch3=0x080B.
    parameter logic [16*P_CHANNELS-1:0]   P_DEF_PORTS = 64'h080B_080A_0809_0808,
    parameter bit                         P_LEN_CHECK = 1'b1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [16*P_CHANNELS-1:0]     i_port_cfg,
    input  logic                         i_port_cfg_valid,
    input  logic [63:0]                  s_axis_ip_data,
    input  logic [55:0]                  s_axis_ip_user,
    input  logic [7:0]                   s_axis_ip_keep,
    input  logic                         s_axis_ip_last,
    input  logic                         s_axis_ip_valid,
    output logic [63:0]                  m_axis_user_data,
    output logic [31:0]                  m_axis_user_user,
    output logic [7:0]                   m_axis_user_keep,
    output logic                         m_axis_user_last,
    output logic                         m_axis_user_valid,
    output logic [15:0]                  o_pkt_ok_cnt,
    output logic [15:0]                  o_pkt_drop_cnt,
    output logic                         o_rx_abort
);

    typedef enum logic [1:0] {
        StIdle,
        StFwd,
        StDiscard
    } state_e;

    state_e state_q, state_d;

    logic [15:0] table_q [P_CHANNELS];

    logic                     in_valid_q;
    logic [63:0]              in_data_q;
    logic [15:0]              in_len_q;
    logic [7:0]               in_keep_q;
    logic                     in_last_q;
    logic                     in_mid_q;
    logic                     first_q;
    logic [16*P_CHANNELS-1:0] cfg_q;
    logic                     cfg_valid_q;

    logic [31:0] user_q, user_d;

    logic        out_valid_q, out_valid_d;
    logic [63:0] out_data_q, out_data_d;
    logic [31:0] out_user_q, out_user_d;
    logic [7:0]  out_keep_q, out_keep_d;
    logic        out_last_q, out_last_d;
    logic        abort_q, abort_d;
    logic [15:0] ok_cnt_q, drop_cnt_q;
    logic        ok_inc, drop_inc;

    logic        unused_user;
    assign unused_user = ^s_axis_ip_user[39:0];

    logic [15:0] hdr_dst;
    logic [15:0] hdr_len;
    logic        match_hit;
    logic [3:0]  match_idx;
    logic        len_ok;
    logic        hdr_fwd;

    assign hdr_dst = in_data_q[47:32];
    assign hdr_len = in_data_q[31:16];

    // Scan from the top down so the lowest matching index wins.
    always_comb begin
        match_hit = 1'b0;
        match_idx = 4'd0;
        for (int i = int'(P_CHANNELS) - 1; i >= 0; i--) begin
            if (table_q[i] == hdr_dst) begin
                match_hit = 1'b1;
                match_idx = 4'(i);
            end
        end
    end

    assign len_ok  = !P_LEN_CHECK || (hdr_len == in_len_q);
    assign hdr_fwd = match_hit && len_ok && (hdr_len > 16'd8) && !in_last_q;

    // Config is staged alongside the data so a load issued with a header beat
    // takes effect only after that header has been matched.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(P_CHANNELS); i++) begin
                table_q[i] <= P_DEF_PORTS[16*i +: 16];
            end
            cfg_q       <= '0;
            cfg_valid_q <= 1'b0;
        end else begin
            cfg_q       <= i_port_cfg;
            cfg_valid_q <= i_port_cfg_valid;
            if (cfg_valid_q) begin
                for (int i = 0; i < int'(P_CHANNELS); i++) begin
                    table_q[i] <= cfg_q[16*i +: 16];
                end
            end
        end
    end

    // A beat captured right after reset belongs to a packet whose header was lost.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            in_valid_q <= 1'b0;
            in_data_q  <= '0;
            in_len_q   <= '0;
            in_keep_q  <= 8'hFF;
            in_last_q  <= 1'b0;
            in_mid_q   <= 1'b0;
            first_q    <= 1'b1;
        end else begin
            in_valid_q <= s_axis_ip_valid;
            in_data_q  <= s_axis_ip_data;
            in_len_q   <= s_axis_ip_user[55:40];
            in_keep_q  <= s_axis_ip_keep;
            in_last_q  <= s_axis_ip_last;
            in_mid_q   <= first_q && s_axis_ip_valid;
            first_q    <= 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        user_d      = user_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_user_d  = out_user_q;
        out_keep_d  = 8'hFF;
        out_last_d  = 1'b0;
        abort_d     = 1'b0;
        ok_inc      = 1'b0;
        drop_inc    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid_q) begin
                    if (in_mid_q) begin
                        state_d = in_last_q ? StIdle : StDiscard;
                    end else if (hdr_fwd) begin
                        state_d = StFwd;
                        user_d  = {hdr_len - 16'd8, 12'd0, match_idx};
                    end else begin
                        drop_inc = 1'b1;
                        state_d  = in_last_q ? StIdle : StDiscard;
                    end
                end
            end
            StFwd: begin
                if (!in_valid_q) begin
                    abort_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_data_q;
                    out_user_d  = user_q;
                    out_keep_d  = in_last_q ? in_keep_q : 8'hFF;
                    out_last_d  = in_last_q;
                    if (in_last_q) begin
                        ok_inc  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StDiscard: begin
                if (!in_valid_q) begin
                    abort_d = 1'b1;
                    state_d = StIdle;
                end else if (in_last_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            user_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_user_q  <= '0;
            out_keep_q  <= 8'hFF;
            out_last_q  <= 1'b0;
            abort_q     <= 1'b0;
            ok_cnt_q    <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            user_q      <= user_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_user_q  <= out_user_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            abort_q     <= abort_d;
            ok_cnt_q    <= ok_cnt_q + {15'd0, ok_inc};
            drop_cnt_q  <= drop_cnt_q + {15'd0, drop_inc};
        end
    end

    assign m_axis_user_data  = out_data_q;
    assign m_axis_user_user  = out_user_q;
    assign m_axis_user_keep  = out_keep_q;
    assign m_axis_user_last  = out_last_q;
    assign m_axis_user_valid = out_valid_q;
    assign o_pkt_ok_cnt      = ok_cnt_q;
    assign o_pkt_drop_cnt    = drop_cnt_q;
    assign o_rx_abort        = abort_q;

endmodule

// File: tb/tb_udp_rx_port_demux.sv
// Bench for udp_rx_port_demux: one instance with the length check, one without, fed the
// same packets; a table of packet vectors drives a scoreboard of expected output beats.
module tb_udp_rx_port_demux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] cfg = '0;
    logic        cfg_valid = 1'b0;
    logic [63:0] s_data = '0;
    logic [55:0] s_user = '0;
    logic [7:0]  s_keep = '0;
    logic        s_last = 1'b0;
    logic        s_valid = 1'b0;

    logic [63:0] data_a, data_b;
    logic [31:0] user_a, user_b;
    logic [7:0]  keep_a, keep_b;
    logic        last_a, last_b, valid_a, valid_b, abort_a, abort_b;
    logic [15:0] ok_a, ok_b, drop_a, drop_b;

    always #5 clk = ~clk;

    udp_rx_port_demux #(.P_LEN_CHECK(1'b1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_port_cfg(cfg), .i_port_cfg_valid(cfg_valid),
        .s_axis_ip_data(s_data), .s_axis_ip_user(s_user), .s_axis_ip_keep(s_keep),
        .s_axis_ip_last(s_last), .s_axis_ip_valid(s_valid),
        .m_axis_user_data(data_a), .m_axis_user_user(user_a), .m_axis_user_keep(keep_a),
        .m_axis_user_last(last_a), .m_axis_user_valid(valid_a),
        .o_pkt_ok_cnt(ok_a), .o_pkt_drop_cnt(drop_a), .o_rx_abort(abort_a)
    );

    udp_rx_port_demux #(.P_LEN_CHECK(1'b0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_port_cfg(cfg), .i_port_cfg_valid(cfg_valid),
        .s_axis_ip_data(s_data), .s_axis_ip_user(s_user), .s_axis_ip_keep(s_keep),
        .s_axis_ip_last(s_last), .s_axis_ip_valid(s_valid),
        .m_axis_user_data(data_b), .m_axis_user_user(user_b), .m_axis_user_keep(keep_b),
        .m_axis_user_last(last_b), .m_axis_user_valid(valid_b),
        .o_pkt_ok_cnt(ok_b), .o_pkt_drop_cnt(drop_b), .o_rx_abort(abort_b)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [31:0] user;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        logic [15:0] dst;
        logic [15:0] udp_len;
        logic [15:0] ip_len;
        int          nbeats;
        logic [7:0]  last_keep;
        int          abort_after;
        bit          gap;
        bit          cfg_load;
        logic [63:0] cfg;
    } vec_t;

    beat_t       q_a[$];
    beat_t       q_b[$];
    logic [15:0] tbl[4];
    int          exp_ok[2];
    int          exp_drop[2];
    int          exp_abort;
    int          seen_abort_a;
    int          seen_abort_b;
    int          checks;
    int          errors;
    vec_t        vecs[13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] dst, input logic [15:0] udp_len,
                                input logic [15:0] ip_len, input int nbeats,
                                input logic [7:0] last_keep, input int abort_after,
                                input bit gap, input bit cfg_load);
        vec_t v;
        v.dst = dst; v.udp_len = udp_len; v.ip_len = ip_len; v.nbeats = nbeats;
        v.last_keep = last_keep; v.abort_after = abort_after; v.gap = gap;
        v.cfg_load = cfg_load; v.cfg = {4{16'h0808}};
        return v;
    endfunction

    function automatic int model_match(input logic [15:0] dst);
        for (int i = 0; i < 4; i++) begin
            if (tbl[i] == dst) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        tbl[0] = 16'h0808; tbl[1] = 16'h0809; tbl[2] = 16'h080A; tbl[3] = 16'h080B;
        exp_ok[0] = 0; exp_ok[1] = 0; exp_drop[0] = 0; exp_drop[1] = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_ok_a"}, ok_a, 16'(exp_ok[0]));
        check({tag, "_ok_b"}, ok_b, 16'(exp_ok[1]));
        check({tag, "_drop_a"}, drop_a, 16'(exp_drop[0]));
        check({tag, "_drop_b"}, drop_b, 16'(exp_drop[1]));
        check({tag, "_abort_a"}, seen_abort_a, exp_abort);
        check({tag, "_abort_b"}, seen_abort_b, exp_abort);
        check({tag, "_pending_a"}, q_a.size(), 0);
        check({tag, "_pending_b"}, q_b.size(), 0);
    endtask

    task automatic idle_and_check(input string tag);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0; cfg_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic send_vec(input vec_t v, input int n);
        int    idx;
        bit    fa;
        bit    fb;
        int    last_k;
        beat_t b;
        idx = model_match(v.dst);
        fb  = (idx >= 0) && (v.udp_len > 16'd8) && (v.nbeats > 1);
        fa  = fb && (v.udp_len == v.ip_len);
        last_k = (v.abort_after > 0) ? v.abort_after : v.nbeats - 1;
        @(posedge clk); #1;
        s_valid   = 1'b1;
        s_data    = {16'hC0DE, v.dst, v.udp_len, 16'h1357};
        s_user    = {v.ip_len, 40'hA5_A5A5_A5A5};
        s_keep    = 8'h3C;
        s_last    = (v.nbeats == 1);
        cfg_valid = v.cfg_load;
        cfg       = v.cfg;
        if (v.cfg_load) begin
            for (int i = 0; i < 4; i++) tbl[i] = v.cfg[16*i +: 16];
        end
        if (!fa) exp_drop[0]++;
        if (!fb) exp_drop[1]++;
        for (int k = 1; k <= last_k; k++) begin
            @(posedge clk); #1;
            cfg_valid = 1'b0;
            s_data    = {$urandom, $urandom};
            s_last    = (k == v.nbeats - 1);
            s_keep    = s_last ? v.last_keep : 8'($urandom);
            b.data    = s_data;
            b.user    = {v.udp_len - 16'd8, 12'd0, 4'(idx)};
            b.keep    = s_last ? v.last_keep : 8'hFF;
            b.last    = s_last;
            if (fa) q_a.push_back(b);
            if (fb) q_b.push_back(b);
        end
        if (v.abort_after > 0) begin
            exp_abort++;
        end else begin
            if (fa) exp_ok[0]++;
            if (fb) exp_ok[1]++;
        end
        if (v.gap) idle_and_check($sformatf("vec%0d", n));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_a) begin
                if (q_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat_a actual=%0h required=none", {data_a, user_a, keep_a, last_a});
                end else begin
                    check("beat_a", {data_a, user_a, keep_a, last_a}, q_a.pop_front());
                end
            end
            if (valid_b) begin
                if (q_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat_b actual=%0h required=none", {data_b, user_b, keep_b, last_b});
                end else begin
                    check("beat_b", {data_b, user_b, keep_b, last_b}, q_b.pop_front());
                end
            end
            if (abort_a) seen_abort_a++;
            if (abort_b) seen_abort_b++;
        end
    end

    initial begin
        checks = 0; errors = 0; exp_abort = 0; seen_abort_a = 0; seen_abort_b = 0;
        model_reset();

        vecs[0]  = mk(16'h0809, 16'd24, 16'd24, 3, 8'hFF, 0, 1'b1, 1'b0);
        vecs[1]  = mk(16'h1234, 16'd24, 16'd24, 3, 8'hFF, 0, 1'b1, 1'b0);
        vecs[2]  = mk(16'h0808, 16'd20, 16'd24, 3, 8'h0F, 0, 1'b1, 1'b0);
        vecs[3]  = mk(16'h0808, 16'd24, 16'd24, 3, 8'hFF, 0, 1'b0, 1'b0);
        vecs[4]  = mk(16'h080B, 16'd20, 16'd20, 3, 8'h0F, 0, 1'b1, 1'b0);
        vecs[5]  = mk(16'h0808, 16'd8,  16'd8,  1, 8'hFF, 0, 1'b1, 1'b0);
        vecs[6]  = mk(16'h080A, 16'd8,  16'd8,  2, 8'h01, 0, 1'b1, 1'b0);
        vecs[7]  = mk(16'h0809, 16'd24, 16'd24, 3, 8'h07, 0, 1'b1, 1'b1);
        vecs[8]  = mk(16'h0808, 16'd32, 16'd32, 4, 8'h3F, 0, 1'b1, 1'b0);
        vecs[9]  = mk(16'h0809, 16'd24, 16'd24, 3, 8'hFF, 0, 1'b1, 1'b0);
        vecs[10] = mk(16'h0808, 16'd40, 16'd40, 5, 8'hFF, 2, 1'b1, 1'b0);
        vecs[11] = mk(16'h0808, 16'd24, 16'd24, 3, 8'h1F, 0, 1'b1, 1'b0);
        vecs[12] = mk(16'h1234, 16'd40, 16'd40, 5, 8'hFF, 1, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", valid_a, 1'b0);
        check("rst_last", last_a, 1'b0);
        check("rst_keep_a", keep_a, 8'hFF);
        check("rst_keep_b", keep_b, 8'hFF);
        check("rst_user", user_a, 32'd0);
        check("rst_data", data_a, 64'd0);
        check("rst_abort", abort_a, 1'b0);
        check_state("rst");

        for (int n = 0; n < 13; n++) send_vec(vecs[n], n);

        // Reset lands mid-packet; the rest of the packet must be swallowed silently.
        @(posedge clk); #1;
        s_valid = 1'b1; s_last = 1'b0; s_keep = 8'hFF;
        s_data  = {16'hC0DE, 16'h0808, 16'd48, 16'h0};
        s_user  = {16'd48, 40'd0};
        @(posedge clk); #1;
        rst = 1'b1; s_data = {$urandom, $urandom};
        @(posedge clk); #1;
        rst = 1'b0; s_data = {$urandom, $urandom};
        model_reset();
        @(posedge clk); #1;
        s_data = {$urandom, $urandom};
        @(posedge clk); #1;
        s_data = {$urandom, $urandom}; s_last = 1'b1;
        idle_and_check("rst_mid");

        // Table is back at defaults after reset: 0x080A lands on channel 2.
        send_vec(mk(16'h080A, 16'd16, 16'd16, 2, 8'h03, 0, 1'b1, 1'b0), 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
